input_port: RTL and testbench

INPUT_PORT -- requirements
Module: input_port

---
 rtl/input_port.sv | 149 ++++++++++++++
 tb/tb_input_port.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/input_port.sv
// Debounced input port: synchronizes and debounces WIDTH pins (KEY[1:0] +
// SW[3:0] by default) and exposes them on a small memory-mapped window
// with change-capture flags, an interrupt mask and a level interrupt.
//   +0 STATE  RO    debounced pin levels
//   +4 EDGE   R/W1C per-bit "level changed" flags
//   +8 MASK   RW    per-bit interrupt enable
module input_port #(
  parameter int          WIDTH           = 6,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0210,
  parameter int          DEBOUNCE_CYCLES = 500000
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_pins,
  input  logic [31:0]      i_addr,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata,
  output logic             o_rvalid,
  output logic             o_irq
);

  // Counter only has to reach DEBOUNCE_CYCLES-1, so it can never wrap.
  localparam int            CW         = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [29:0]   WORD_STATE = BASE_ADDR[31:2];
  localparam logic [29:0]   WORD_EDGE  = BASE_ADDR[31:2] + 30'd1;
  localparam logic [29:0]   WORD_MASK  = BASE_ADDR[31:2] + 30'd2;

  logic [WIDTH-1:0] sync_q0;
  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] stable_q;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] w1c;
  logic [29:0]      word;
  logic             hit_state;
  logic             hit_edge;
  logic             hit_mask;
  logic             hit_any;
  logic [31:0]      rd_word;
  logic             unused_bits;

  // Byte-lane bits and bus bits above WIDTH carry no meaning for this block.
  assign unused_bits = ^{i_addr[1:0], i_wdata[31:WIDTH]};

  assign word      = i_addr[31:2];
  assign hit_state = (word == WORD_STATE);
  assign hit_edge  = (word == WORD_EDGE);
  assign hit_mask  = (word == WORD_MASK);
  assign hit_any   = hit_state | hit_edge | hit_mask;

  // Two-flop synchronizer on every raw pin to tame metastability.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_q0 <= '0;
      sync_q1 <= '0;
    end else begin
      sync_q0 <= i_pins;
      sync_q1 <= sync_q0;
    end
  end

  // A bit is accepted once its synchronized level has differed from the
  // stable level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    load = '0;
    for (int i = 0; i < WIDTH; i++) begin
      load[i] = (sync_q1[i] != stable_q[i]) && (cnt_q[i] == CNT_MAX);
    end
  end

  // Per-bit debounce counters and the accepted (stable) levels.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q1[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (load[i]) begin
          stable_q[i] <= sync_q1[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign w1c = (i_we && hit_edge) ? i_wdata[WIDTH-1:0] : '0;

  // Change flags: a newly accepted level sets its bit and beats a same-cycle clear.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      edge_q <= '0;
    end else begin
      edge_q <= (edge_q & ~w1c) | load;
    end
  end

  // Interrupt enable register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      mask_q <= '0;
    end else if (i_we && hit_mask) begin
      mask_q <= i_wdata[WIDTH-1:0];
    end
  end

  // Read mux over the current (pre-update) register values.
  always_comb begin
    rd_word = '0;
    if (hit_state) begin
      rd_word = 32'(stable_q);
    end else if (hit_edge) begin
      rd_word = 32'(edge_q);
    end else if (hit_mask) begin
      rd_word = 32'(mask_q);
    end
  end

  // Registered read response, one cycle after the strobe.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
    end else begin
      o_rvalid <= i_re && hit_any;
      o_rdata  <= (i_re && hit_any) ? rd_word : 32'h0;
    end
  end

  // Level interrupt from last cycle's flags and enables.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= |(edge_q & mask_q);
    end
  end

endmodule

// File: tb/tb_input_port.sv
// Directed bench for input_port with a 4-cycle debounce window.
module tb_input_port;

  localparam int          WIDTH    = 6;
  localparam logic [31:0] A_STATE  = 32'h0000_0210;
  localparam logic [31:0] A_EDGE   = 32'h0000_0214;
  localparam logic [31:0] A_MASK   = 32'h0000_0218;

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] pins;
  logic [31:0]      addr;
  logic             we;
  logic             re;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic             rvalid;
  logic             irq;

  int assert_count = 0;
  int fail_count   = 0;

  input_port #(
    .WIDTH          (WIDTH),
    .BASE_ADDR      (32'h0000_0210),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .i_clock (clock),
    .i_reset (reset),
    .i_pins  (pins),
    .i_addr  (addr),
    .i_we    (we),
    .i_re    (re),
    .i_wdata (wdata),
    .o_rdata (rdata),
    .o_rvalid(rvalid),
    .o_irq   (irq)
  );

  // 10 ns system clock.
  always #5 clock = ~clock;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    check_output({tag, "_rvalid"}, 32'(rvalid), 32'h1);
    check_output({tag, "_rdata"}, rdata, exp);
  endtask

  task automatic do_read_none(input string tag, input logic [31:0] a);
    addr = a;
    re   = 1'b1;
    tick();
    re   = 1'b0;
    check_output({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    check_output({tag, "_rdata"}, rdata, 32'h0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset = 1'b1;
    pins  = '0;
    addr  = '0;
    we    = 1'b0;
    re    = 1'b0;
    wdata = '0;
    ticks(2);
    check_output("rst_rvalid", 32'(rvalid), 32'h0);
    check_output("rst_rdata", rdata, 32'h0);
    check_output("rst_irq", 32'(irq), 32'h0);
    reset = 1'b0;
    ticks(2);

    $display("[TB] pin 0 rise debounce");
    pins = 6'b000001;
    ticks(5);
    do_read("state_early", A_STATE, 32'h0);
    do_read("state_late", A_STATE, 32'h1);
    do_read("edge_pin0", A_EDGE, 32'h1);
    check_output("irq_unmasked", 32'(irq), 32'h0);

    $display("[TB] clear flags, enable mask, short glitch on pin 2");
    do_write(A_EDGE, 32'h3F);
    do_write(A_MASK, 32'h3F);
    tick();
    check_output("irq_after_clear", 32'(irq), 32'h0);
    pins = 6'b000101;
    ticks(3);
    pins = 6'b000001;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("glitch_irq", 32'(irq), 32'h0);
    end
    do_read("glitch_state", A_STATE, 32'h1);
    do_read("glitch_edge", A_EDGE, 32'h0);

    $display("[TB] pin 1 rise with interrupt");
    pins = 6'b000011;
    ticks(6);
    check_output("irq_same_cycle", 32'(irq), 32'h0);
    tick();
    check_output("irq_set", 32'(irq), 32'h1);
    do_write(A_EDGE, 32'h2);
    check_output("irq_hold", 32'(irq), 32'h1);
    tick();
    check_output("irq_cleared", 32'(irq), 32'h0);
    do_read("edge_cleared", A_EDGE, 32'h0);

    $display("[TB] W1C colliding with new pin 0 edge");
    pins = 6'b000010;
    ticks(5);
    do_write(A_EDGE, 32'h1);
    do_read("edge_set_wins", A_EDGE, 32'h1);
    do_write(A_EDGE, 32'h3F);
    do_read("edge_w1c", A_EDGE, 32'h0);

    $display("[TB] decode and register access");
    do_write(A_STATE, 32'h3F);
    do_read("state_ro", A_STATE, 32'h2);
    do_read_none("oow_high", 32'h0000_0220);
    do_read_none("oow_low", 32'h0000_0208);
    do_write(A_MASK, 32'hFFFF_FFFF);
    do_read("mask_full", A_MASK, 32'h3F);
    do_read("mask_byte", 32'h0000_021B, 32'h3F);
    addr  = A_MASK;
    wdata = 32'h0;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we    = 1'b0;
    re    = 1'b0;
    check_output("rw_rvalid", 32'(rvalid), 32'h1);
    check_output("rw_prewrite", rdata, 32'h3F);
    do_read("mask_written", A_MASK, 32'h0);
    addr = A_STATE;
    re   = 1'b1;
    tick();
    check_output("b2b_rvalid0", 32'(rvalid), 32'h1);
    check_output("b2b_rdata0", rdata, 32'h2);
    addr = A_EDGE;
    tick();
    re   = 1'b0;
    check_output("b2b_rvalid1", 32'(rvalid), 32'h1);
    check_output("b2b_rdata1", rdata, 32'h0);
    tick();
    check_output("b2b_idle", 32'(rvalid), 32'h0);
    do_write(A_MASK, 32'h3F);

    $display("[TB] reset mid-debounce with a pending read");
    pins = 6'b000000;
    ticks(4);
    addr = A_STATE;
    re   = 1'b1;
    #2;
    reset = 1'b1;
    @(posedge clock);
    #1;
    re = 1'b0;
    check_output("rst_read_rvalid", 32'(rvalid), 32'h0);
    tick();
    reset = 1'b0;
    check_output("rst_irq2", 32'(irq), 32'h0);
    do_read("post_rst_state", A_STATE, 32'h0);
    do_read("post_rst_edge", A_EDGE, 32'h0);
    do_read("post_rst_mask", A_MASK, 32'h0);
    ticks(6);
    do_read("post_rst_state2", A_STATE, 32'h0);

    $display("[TB] pins held high through reset release");
    reset = 1'b1;
    pins  = 6'b000010;
    tick();
    reset = 1'b0;
    ticks(5);
    do_read("held_state_early", A_STATE, 32'h0);
    do_read("held_state", A_STATE, 32'h2);
    do_read("held_edge", A_EDGE, 32'h2);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
